// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
// over the shared open-drain clock/data lines. The full host request is run:
// clock inhibit, start bit, 8 data bits (LSB first), odd parity, stop bit and
// the device acknowledge. The outputs are output-enables only. A 1 pulls the
// line low and a 0 releases it; the top level maps them onto tristate pads.
//
// Ports
//   clk          system clock, rising edge
//   resetN       asynchronous active-low reset
//   txData       command byte, valid together with txValid
//   txValid      request to send
//   txReady      idle and able to accept a byte
//   keyboardCLK  PS/2 clock pad (raw, asynchronous)
//   keyboardData PS/2 data pad (raw, asynchronous)
//   ps2ClkOe     1 = pull PS/2 clock low
//   ps2DataOe    1 = pull PS/2 data low
//   txDone       one-cycle pulse, transfer acknowledged
//   txError      one-cycle pulse, transfer failed
//   errCode      01 = timeout, 10 = no ack; holds until the next txError
//
// INHIBIT_CYCLES must be at least 2, because the start bit is raised one
// cycle before the clock inhibit ends.

module ps2_host_tx #(
  parameter int CLK_HZ         = 50000000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       keyboardCLK,
  input  logic       keyboardData,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  output logic       txDone,
  output logic       txError,
  output logic [1:0] errCode
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NO_ACK = 2'b10;

  // Elaboration-time sanity check of the configuration.
  if (INHIBIT_CYCLES < 2 || FILTER_LEN < 1 || CLK_HZ < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_cfg
    $error("ps2_host_tx: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // The PS/2 frame carries odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t            state_r;
  state_t            next_s;
  logic [7:0]        data_r;
  logic              parity_r;
  logic [3:0]        bit_idx_r;
  logic [3:0]        bit_idx_s;
  logic [INH_W-1:0]  inh_cnt_r;
  logic [INH_W-1:0]  inh_cnt_s;
  logic [19:0]       to_cnt_r;
  logic              clk_sync1_r;
  logic              clk_sync2_r;
  logic              data_sync1_r;
  logic              data_sync2_r;
  logic [FLT_W-1:0]  filt_cnt_r;
  logic              clk_filt_r;
  logic              clk_filt_d_r;
  logic              clk_oe_r;
  logic              clk_oe_s;
  logic              data_oe_r;
  logic              data_oe_s;
  logic              ready_r;
  logic              ready_s;
  logic              done_r;
  logic              done_s;
  logic              error_r;
  logic              error_s;
  logic [1:0]        err_code_r;
  logic [1:0]        err_code_s;
  logic              load_s;
  logic              fall_s;
  logic              timed_s;
  logic              timeout_s;

  // Two-flop synchronizers for both pads; idle bus is high.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_sync1_r  <= 1'b1;
      clk_sync2_r  <= 1'b1;
      data_sync1_r <= 1'b1;
      data_sync2_r <= 1'b1;
    end else begin
      clk_sync1_r  <= keyboardCLK;
      clk_sync2_r  <= clk_sync1_r;
      data_sync1_r <= keyboardData;
      data_sync2_r <= data_sync1_r;
    end
  end

  // Clock filter: follow the synchronized clock only after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      filt_cnt_r   <= FLT_W'(0);
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync2_r == clk_filt_r) begin
        filt_cnt_r <= FLT_W'(0);
      end else if (filt_cnt_r == FLT_LAST) begin
        clk_filt_r <= clk_sync2_r;
        filt_cnt_r <= FLT_W'(0);
      end else begin
        filt_cnt_r <= filt_cnt_r + FLT_W'(1);
      end
    end
  end

  assign fall_s    = clk_filt_d_r & ~clk_filt_r;
  assign timed_s   = (state_r == ST_REQ) || (state_r == ST_DATA) ||
                     (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);
  assign timeout_s = timed_s && (to_cnt_r >= TO_LAST);

  // Timeout counter: zero outside the device-clocked phase, saturating inside it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      to_cnt_r <= 20'd0;
    end else if (!timed_s) begin
      to_cnt_r <= 20'd0;
    end else if (to_cnt_r != 20'hFFFFF) begin
      to_cnt_r <= to_cnt_r + 20'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Byte and parity capture on acceptance.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      data_r   <= 8'h00;
      parity_r <= 1'b0;
    end else if (load_s) begin
      data_r   <= txData;
      parity_r <= odd_parity(txData);
    end else begin
      data_r   <= data_r;
      parity_r <= parity_r;
    end
  end

  // FSM state register together with all registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= 4'd0;
      inh_cnt_r  <= INH_W'(0);
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      state_r    <= next_s;
      bit_idx_r  <= bit_idx_s;
      inh_cnt_r  <= inh_cnt_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      ready_r    <= ready_s;
      done_r     <= done_s;
      error_r    <= error_s;
      err_code_r <= err_code_s;
    end
  end

  // Next-state logic and the values the output registers take at the next edge.
  always_comb begin
    next_s     = state_r;
    bit_idx_s  = bit_idx_r;
    inh_cnt_s  = inh_cnt_r;
    clk_oe_s   = clk_oe_r;
    data_oe_s  = data_oe_r;
    done_s     = 1'b0;
    error_s    = 1'b0;
    err_code_s = err_code_r;
    load_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        if (txValid && ready_r) begin
          next_s    = ST_INHIBIT;
          clk_oe_s  = 1'b1;
          inh_cnt_s = INH_W'(0);
          load_s    = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        // The start bit goes out one cycle before the clock is released.
        inh_cnt_s = inh_cnt_r + INH_W'(1);
        if (inh_cnt_r == INH_LAST) begin
          next_s    = ST_REQ;
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b1;
        end else if (inh_cnt_r == INH_START) begin
          clk_oe_s  = 1'b1;
          data_oe_s = 1'b1;
        end else begin
          clk_oe_s  = 1'b1;
          data_oe_s = 1'b0;
        end
      end

      ST_REQ: begin
        if (timeout_s) begin
          next_s     = ST_IDLE;
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          error_s    = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else if (fall_s) begin
          next_s    = ST_DATA;
          data_oe_s = ~data_r[0];
          bit_idx_s = 4'd1;
        end else begin
          next_s = ST_REQ;
        end
      end

      ST_DATA: begin
        if (timeout_s) begin
          next_s     = ST_IDLE;
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          error_s    = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else if (fall_s) begin
          case (bit_idx_r)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              data_oe_s = ~data_r[bit_idx_r[2:0]];
              bit_idx_s = bit_idx_r + 4'd1;
            end
            4'd8: begin
              data_oe_s = ~parity_r;
              bit_idx_s = 4'd9;
            end
            4'd9: begin
              // Stop bit is a released line.
              data_oe_s = 1'b0;
              next_s    = ST_ACK;
            end
            default: begin
              next_s    = ST_IDLE;
              data_oe_s = 1'b0;
            end
          endcase
        end else begin
          next_s = ST_DATA;
        end
      end

      ST_ACK: begin
        // A missing ack outranks a timeout that lands on the same cycle.
        if (fall_s && data_sync2_r) begin
          next_s     = ST_IDLE;
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          error_s    = 1'b1;
          err_code_s = ERR_NO_ACK;
        end else if (timeout_s) begin
          next_s     = ST_IDLE;
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          error_s    = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else if (fall_s) begin
          next_s = ST_WAIT_IDLE;
        end else begin
          next_s = ST_ACK;
        end
      end

      ST_WAIT_IDLE: begin
        if (timeout_s) begin
          next_s     = ST_IDLE;
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          error_s    = 1'b1;
          err_code_s = ERR_TIMEOUT;
        end else if (clk_filt_r && data_sync2_r) begin
          next_s = ST_IDLE;
          done_s = 1'b1;
        end else begin
          next_s = ST_WAIT_IDLE;
        end
      end

      default: begin
        next_s    = ST_IDLE;
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
      end
    endcase

    // Ready only once IDLE has been held for a cycle, so it trails done/error.
    ready_s = (state_r == ST_IDLE) && (next_s == ST_IDLE);
  end

  assign txReady   = ready_r;
  assign ps2ClkOe  = clk_oe_r;
  assign ps2DataOe = data_oe_r;
  assign txDone    = done_r;
  assign txError   = error_r;
  assign errCode   = err_code_r;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same two open-drain lines the keyboard receiver listens on. It runs the full host-request sequence: clock inhibit, start bit, 8 data bits, odd parity, stop bit, and device acknowledge. It sits beside the keyboard input block; the top level maps its output-enables onto tristate pads.

## Interface
- `CLK_HZ`, 50000000: system clock frequency; documentation only.
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum cycles from releasing the clock to a sampled ack (15 ms).
- `FILTER_LEN`, 8: consecutive equal samples required to change the filtered PS/2 clock.
- `clk` in 1: system clock; all logic on its rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `txData` in 8: command byte, valid with `txValid`.
- `txValid` in 1: request to send.
- `txReady` out 1: high when idle and able to accept a byte.
- `keyboardCLK` in 1: sampled PS/2 clock pad.
- `keyboardData` in 1: sampled PS/2 data pad.
- `ps2ClkOe` out 1: 1 = drive the PS/2 clock low; 0 = release.
- `ps2DataOe` out 1: 1 = drive the PS/2 data low; 0 = release.
- `txDone` out 1: one-cycle pulse on an acknowledged transfer.
- `txError` out 1: one-cycle pulse on a failed transfer.
- `errCode` out 2: 01 = timeout, 10 = no ack. Holds until the next `txError`.

## Operation
- Input conditioning: both pads pass through 2-FF synchronizers.
- Clock filter: the clock is additionally filtered. The filtered value changes only after `FILTER_LEN` consecutive identical synchronized samples.
- Edge detection: a falling edge is filtered 1→0. The filtered data value is the synchronized data.
- Handshake: a transfer is accepted on a rising edge with `txValid && txReady`. On acceptance, `txData` and parity `~^txData` are latched. `txValid` while not ready is ignored, with no queueing.
- State IDLE: both OEs 0, `txReady`=1. Accept → INHIBIT.
- State INHIBIT: `ps2ClkOe`=1 for `INHIBIT_CYCLES` cycles. `ps2DataOe` rises on the last inhibit cycle (start bit). Then → REQ. The timeout counter starts at REQ entry.
- State REQ: `ps2ClkOe`=0, `ps2DataOe`=1. On the first falling edge: `ps2DataOe`=~bit0, bitIdx=1 → DATA.
- State DATA: on each falling edge, present the next bit.
  - bitIdx 1..7: data bits 1..7, LSB first.
  - bitIdx 8: parity.
  - bitIdx 9: release data (stop=1), → ACK.
  - In every case `ps2DataOe` = inverse of the bit.
- State ACK: on the next (11th) falling edge, sample data.
  - Data 0 → WAIT_IDLE.
  - Data 1 → error 10, → IDLE.
- State WAIT_IDLE: wait until filtered clock and data are both 1. Then pulse `txDone` and go to IDLE.
- Timeout: the counter is checked in REQ, DATA, ACK and WAIT_IDLE. Reaching `TIMEOUT_CYCLES` releases both lines, pulses `txError` with errCode 01, and returns to IDLE.
- Error precedence: if the timeout and a no-ack occur in the same cycle, the no-ack (10) wins.
- Counter: 20 bits wide, saturating; it does not wrap.
- Reset (asynchronous, any state, mid-frame included):
  - State IDLE.
  - OEs 0.
  - `txReady`=1.
  - `txDone`/`txError`=0.
  - `errCode`=00.
  - Filter and synchronizers=1 (idle bus).

## Timing
- Accept at edge N: `txReady`=0 and `ps2ClkOe`=1 from N+1.
- `ps2DataOe`=1 from N+`INHIBIT_CYCLES`.
- `ps2ClkOe`=0 from N+`INHIBIT_CYCLES`+1.
- Data update latency: the bit on `ps2DataOe` changes at most 3+`FILTER_LEN` cycles after the pad falling edge. This is well inside the 30 µs device clock-low phase.
- `txDone`/`txError` are registered one-cycle pulses. `txReady`=1 in the cycle after the pulse.
- Frame overhead is fixed: exactly 11 device falling edges are consumed per successful transfer.
- Glitch rejection: clock low pulses shorter than `FILTER_LEN` cycles produce no edge.

## Test plan
- **Reset:** assert `resetN`=0 mid-DATA at bitIdx 4 → `ps2ClkOe`=`ps2DataOe`=0 within the same cycle, `txReady`=1. After release, IDLE accepts 0xFF normally.
- **Normal 0xED:** device model runs a 12.5 kHz clock with ack low.
  - Clock held low ≥5000 cycles.
  - Data bits on device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One `txDone` pulse, `errCode`=00.
- **Parity:** send 0x01 → parity bit 0. Send 0x00 → parity 1. Both acked, `txDone` each.
- **No ack:** device leaves data high on the 11th falling edge → `txError` pulse, `errCode`=10, both OEs 0, `txReady`=1.
- **Timeout:** device never clocks after the request → `txError` exactly `TIMEOUT_CYCLES` after REQ entry, `errCode`=01, lines released.
- **Glitch and busy:** a 3-cycle low glitch on `keyboardCLK` during DATA leaves bitIdx unchanged and the frame still completes with `txDone`. `txValid` with 0x55 during the transfer is ignored, and only the original byte appears on the bus.
